// File: rtl/cache_mem_ctrl.sv
// Backing-store controller below the direct-mapped cache: line-fill reads, posted write-through writes.
// Latency: read data LATENCY cycles after accept (rd_valid pulse); posted writes commit LATENCY cycles after leaving the buffer.
// Backpressure: wr_ready drops when the write buffer is full; rd_ready holds reads off until the buffer is drained and idle.
module cache_mem_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_req,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_ready,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ready,
  output logic [$clog2(WBUF_DEPTH):0]    wbuf_count,
  output logic                           busy,
  output logic [31:0]                    rd_count,
  output logic [31:0]                    wr_count
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_M1  = LW'(LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

  logic [1:0]            state;
  logic [LW-1:0]         lat_cnt;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_data;

  // Write buffer storage; pointers wrap naturally because the depth is a power of two.
  logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // The backing array itself; never reset so preloaded contents survive.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic push;
  logic pop;
  logic rd_acc;
  logic op_done;

  assign wr_ready = (wbuf_count < DEPTH_C);
  // Writes win over a simultaneous read so a read can never overtake a pending write.
  assign rd_ready = (state == S_IDLE) && (wbuf_count == '0) && !wr_req;
  assign push     = wr_req && wr_ready;
  assign rd_acc   = rd_req && rd_ready;
  // rd_ready already excludes a non-empty buffer, so pop and read-accept are exclusive.
  assign pop      = (state == S_IDLE) && (wbuf_count != '0);
  assign op_done  = (state != S_IDLE) && (lat_cnt == '0);
  assign busy     = (state != S_IDLE) || (wbuf_count != '0);

  // Capture incoming writes into the buffer slot at the tail pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= wr_addr;
      wb_data[wr_ptr] <= wr_data;
    end
  end

  // Buffer pointers and occupancy; a push and pop on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   wbuf_count <= wbuf_count + CW'(1);
        2'b01:   wbuf_count <= wbuf_count - CW'(1);
        default: wbuf_count <= wbuf_count;
      endcase
    end
  end

  // Access sequencer: start a read or drain one buffered write, then count down the latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      op_addr  <= '0;
      op_data  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_acc) begin
            op_addr <= rd_addr;
            lat_cnt <= LAT_M1;
            state   <= S_RD_WAIT;
          end else if (pop) begin
            op_addr <= wb_addr[rd_ptr];
            op_data <= wb_data[rd_ptr];
            lat_cnt <= LAT_M1;
            state   <= S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (lat_cnt == '0) begin
            rd_data  <= mem[op_addr];
            rd_valid <= 1'b1;
            rd_count <= rd_count + 32'd1;
            state    <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        S_WR_WAIT: begin
          if (lat_cnt == '0) begin
            wr_count <= wr_count + 32'd1;
            state    <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit a drained write on its final latency cycle; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_WR_WAIT) && op_done) begin
      mem[op_addr] <= op_data;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
module tb_cache_mem_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [2:0]    wbuf_count;
  logic          busy;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;

  cache_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .wbuf_count(wbuf_count), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           mq[$];
  logic [DW-1:0] mmem [logic [AW-1:0]];
  bit            m_active = 0;
  bit            m_is_rd = 0;
  int            m_done = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_rd_valid = 0;
  logic [DW-1:0] m_rd_data = '0;
  logic [31:0]   m_rdc = 0;
  logic [31:0]   m_wrc = 0;
  bit            model_ok = 0;

  // Server model: one access at a time, each finishing LAT edges after it starts.
  task automatic model_step();
    bit can_wr;
    bit can_rd;
    wr_t w;
    if (reset) begin
      mq.delete();
      m_active   = 0;
      m_rd_valid = 0;
      m_rd_data  = '0;
      m_rdc      = 0;
      m_wrc      = 0;
      model_ok   = 1;
    end else begin
      can_wr = (mq.size() < DEPTH);
      can_rd = !m_active && (mq.size() == 0) && !wr_req;
      m_rd_valid = 0;
      if (m_active) begin
        if (cyc == m_done) begin
          if (m_is_rd) begin
            m_rd_data  = mmem[m_addr];
            m_rd_valid = 1;
            m_rdc++;
          end else begin
            mmem[m_addr] = m_wdata;
            m_wrc++;
          end
          m_active = 0;
        end
      end else if (rd_req && can_rd) begin
        m_active = 1; m_is_rd = 1; m_addr = rd_addr; m_done = cyc + LAT;
      end else if (mq.size() != 0) begin
        w = mq.pop_front();
        m_active = 1; m_is_rd = 0; m_addr = w.a; m_wdata = w.d; m_done = cyc + LAT;
      end
      if (wr_req && can_wr) mq.push_back('{wr_addr, wr_data});
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("rd_valid",   {31'd0, rd_valid}, {31'd0, m_rd_valid});
      chk("rd_data",    {16'd0, rd_data}, {16'd0, m_rd_data});
      chk("rd_count",   rd_count, m_rdc);
      chk("wr_count",   wr_count, m_wrc);
      chk("wbuf_count", {29'd0, wbuf_count}, 32'(mq.size()));
      chk("wr_ready",   {31'd0, wr_ready}, {31'd0, (mq.size() < DEPTH)});
      chk("rd_ready",   {31'd0, rd_ready}, {31'd0, (!m_active && mq.size() == 0 && !wr_req)});
      chk("busy",       {31'd0, busy}, {31'd0, (m_active || mq.size() != 0)});
    end
  end

  // ---------------- stimulus helpers (enter and leave just after a rising edge) ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc_cyc);
    bit ok;
    bit acc = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); ok = wr_ready;
      @(posedge clk); #1;
      if (ok) begin acc = 1; break; end
    end
    wr_req = 1'b0;
    acc_cyc = cyc;
    if (!acc) chk("wr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int acc_cyc);
    bit ok;
    bit acc = 0;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); ok = rd_ready;
      @(posedge clk); #1;
      if (ok) begin acc = 1; break; end
    end
    rd_req = 1'b0;
    acc_cyc = cyc;
    if (!acc) chk("rd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rd(output int t);
    bit seen = 0;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_valid) begin seen = 1; t = cyc; break; end
    end
    @(posedge clk); #1;
    if (!seen) chk("rd_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    if (!seen) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a, b, t;
    int acc [6];

    dut.mem[16'h0010] = 16'hAAAA; mmem[16'h0010] = 16'hAAAA;
    dut.mem[16'h0050] = 16'h0000; mmem[16'h0050] = 16'h0000;
    dut.mem[16'h0020] = 16'hBEEF; mmem[16'h0020] = 16'hBEEF;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rd_count", rd_count, 32'd0);
    chk("reset_wbuf", {29'd0, wbuf_count}, 32'd0);
    chk("reset_rd_ready", {31'd0, rd_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Single read of preloaded data.
    do_read(16'h0010, a);
    wait_rd(t);
    chk("t1_latency", 32'(t - a), 32'd4);
    chk("t1_data", {16'd0, rd_data}, 32'h0000AAAA);
    chk("t1_rd_count", rd_count, 32'd1);
    wait_idle();

    // Read right behind a write to the same address.
    do_write(16'h0030, 16'hCCCC, a);
    do_read(16'h0030, b);
    chk("t2_read_held", 32'(b - a), 32'd6);
    chk("t2_wr_count", wr_count, 32'd1);
    wait_rd(t);
    chk("t2_data", {16'd0, rd_data}, 32'h0000CCCC);

    // Six back-to-back writes overflow a four-deep buffer.
    for (int i = 0; i < 6; i++) begin
      do_write(16'(16'h0040 + i), 16'(16'h1000 + i), acc[i]);
      if (i == 4) chk("t3_full", {31'd0, wr_ready}, 32'd0);
    end
    chk("t3_sixth_delay", 32'(acc[5] - acc[0]), 32'd7);
    wait_idle();
    chk("t3_wr_count", wr_count, 32'd7);
    chk("t3_wbuf_empty", {29'd0, wbuf_count}, 32'd0);
    do_read(16'h0040, a); wait_rd(t);
    chk("t3_first", {16'd0, rd_data}, 32'h00001000);
    do_read(16'h0045, a); wait_rd(t);
    chk("t3_last", {16'd0, rd_data}, 32'h00001005);

    // Simultaneous read and write to the same address: write goes first.
    fork
      do_write(16'h0050, 16'h5555, a);
      do_read(16'h0050, b);
    join
    chk("t4_order", 32'(b - a), 32'd6);
    wait_rd(t);
    chk("t4_data", {16'd0, rd_data}, 32'h00005555);

    // Same-address writes commit in order.
    do_write(16'h0011, 16'h1111, a);
    do_write(16'h0011, 16'h2222, a);
    do_read(16'h0011, b);
    wait_rd(t);
    chk("t5_data", {16'd0, rd_data}, 32'h00002222);
    chk("t5_rd_count", rd_count, 32'd6);

    // Reset in the middle of a read: aborted, memory untouched.
    do_read(16'h0020, a);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_rd_ready", {31'd0, rd_ready}, 32'd1);
    chk("t6_rd_count", rd_count, 32'd0);
    chk("t6_rd_data", {16'd0, rd_data}, 32'd0);
    chk("t6_wr_count", wr_count, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_valid", {31'd0, rd_valid}, 32'd0);
    end
    @(posedge clk); #1;
    do_read(16'h0020, a); wait_rd(t);
    chk("t6_mem_kept", {16'd0, rd_data}, 32'h0000BEEF);
    do_read(16'h0010, a); wait_rd(t);
    chk("t6_mem_kept2", {16'd0, rd_data}, 32'h0000AAAA);
    chk("t6_rd_count_after", rd_count, 32'd2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
